lsb_x: RTL
==========

// Module: lsb_x
// PURPOSE
//  Parametrised LEDs/switches/buttons I/O device: N debounced buttons, N debounced switches, M LEDs.
//  Adds sticky button-press/release event latches, per-event interrupt enables, and an LED toggle register.
//  Sits on the CPU I/O bus as a single-cycle-ack peripheral, four word registers selected by addr.
// PARAMETERS
//  NUM_BTN      4        buttons, 1..16
//  NUM_SWI      4        switches, 1..16
//  NUM_LED      8        LEDs, 1..32
//  DBNC_CYCLES  100000   consecutive stable cycles before a debounced output changes, >=2
//  BTN_POL      1        1: button pressed = input high; 0: pressed = input low (applies to all buttons)
//  SWI_POL      1        same for switches
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous reset, active high
//  stb       in   1        bus strobe, device selected this cycle
//  we        in   1        1 write, 0 read
//  addr      in   2        register select (see BEHAVIOUR)
//  data_in   in   32       write data
//  data_out  out  32       read data, combinational, 0 when not reading
//  ack       out  1        = stb
//  btn_in    in   NUM_BTN  raw button pins, asynchronous
//  swi_in    in   NUM_SWI  raw switch pins, asynchronous
//  leds      out  NUM_LED  LED drive, registered
//  btn_out   out  NUM_BTN  debounced buttons, active high after polarity fix
//  swi_out   out  NUM_SWI  debounced switches, active high after polarity fix
//  irq       out  1        level interrupt, registered
// BEHAVIOUR
//  Clock/reset: one clock clk; reset is synchronous and active-high (rst), sampled at posedge clk.
//  Reset: leds=0, btn_out=0, swi_out=0, evt=0, ien=0, irq=0, debounce counters=0, synchronisers=0.
//  Debounce (per bit): 2-flop synchroniser, polarity normalisation, then counter; counter increments while
//   sync value != debounced output, clears when equal; at count DBNC_CYCLES-1 output flips and counter clears.
//   Pulses shorter than DBNC_CYCLES never reach the output. Latency input edge -> output = 2+DBNC_CYCLES clk.
//  Reset mid-debounce: counter and output forced to 0; a level held active restarts full debounce after rst low.
//  Registers (read: stb&~we, combinational; write: stb&we, takes effect next posedge):
//   addr 0 DATA  R: {btn_out zero-ext to 16, swi_out zero-ext to 16}  W: leds <= data_in[NUM_LED-1:0]
//   addr 1 EVT   R: {release[15:0], press[15:0]} (zero-ext)  W: write-1-to-clear, same bit layout
//   addr 2 IEN   R/W: interrupt enable mask, same layout as EVT; unused bits read 0
//   addr 3 LTOG  R: leds zero-ext   W: leds <= leds ^ data_in[NUM_LED-1:0]
//  Events: press[i] set on debounced btn_out[i] 0->1, release[i] on 1->0; sticky until cleared.
//   Same-cycle set and W1C clear on one bit: set wins (event kept).
//  irq <= |(evt & ien) registered: asserts 1 cycle after the evt/ien update, deasserts 1 cycle after clear.
//  Writes with stb low ignored; reads have no side effects; ack every stb cycle, no wait states.
//  Unused data_in bits ignored; unused data_out bits 0.
// STRUCTURE
//  lsb_pkg: register address constants (LSB_DATA=0, LSB_EVT=1, LSB_IEN=2, LSB_LTOG=3), field offsets
//   (PRESS_LSB=0, RELEASE_LSB=16), max widths (16 btn/swi, 32 led).
//  Sub-module dbnc_v #(WIDTH, CYCLES, POL): vector synchroniser+debouncer, instantiated once for
//   buttons and once for switches. Event, register, irq logic in lsb_x. Counter width $clog2(DBNC_CYCLES).
// TESTING (bench with DBNC_CYCLES=8)
//  btn_in[1] high held -> btn_out[1] rises exactly 10 clk later; DATA read = 0x0002_0000; EVT = 0x0000_0002.
//  btn_in[0] glitch high 5 clk then low -> btn_out stays 0, EVT stays 0.
//  IEN write 0x0000_0002, then press btn 1 -> irq high 1 clk after press bit; EVT write 0x2 -> irq low 1 clk after.
//  Release btn 1 in the same cycle EVT W1C 0x0002_0000 written -> release bit remains set.
//  DATA write 0xA5 then LTOG write 0x0F -> leds=0xAA; LTOG read = 0x0000_00AA.
//  rst pulse during debounce count 5 with input held -> all outputs 0, btn_out rises 10 clk after rst drops.

Source files
------------

// File: rtl/lsb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsb_pkg
// Brief    : Register map, event field offsets and width limits for lsb_x.
// Revision : 1.0  initial release
// ============================================================================
package lsb_pkg;

    localparam logic [1:0] LSB_DATA = 2'd0;
    localparam logic [1:0] LSB_EVT  = 2'd1;
    localparam logic [1:0] LSB_IEN  = 2'd2;
    localparam logic [1:0] LSB_LTOG = 2'd3;

    localparam int PRESS_LSB   = 0;
    localparam int RELEASE_LSB = 16;

    localparam int MAX_BTN = 16;
    localparam int MAX_SWI = 16;
    localparam int MAX_LED = 32;

    // Bits of the EVT/IEN word that exist for a given button count.
    function automatic logic [31:0] evt_mask(input int nbtn);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < nbtn; i++) begin
            m[PRESS_LSB + i]   = 1'b1;
            m[RELEASE_LSB + i] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_x_dbnc_v.sv
`default_nettype none
// ============================================================================
// Module   : dbnc_v
// Brief    : Vector 2-flop synchroniser, polarity fix and per-bit debouncer.
// Revision : 1.0  initial release
// ============================================================================
module dbnc_v #(
    parameter int WIDTH  = 4,
    parameter int CYCLES = 100000,
    parameter int POL    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int             CW     = $clog2(CYCLES);
    localparam logic [CW-1:0]  c_last = CW'(CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl = (POL != 0) ? r_sync2 : ~r_sync2;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] r_cnt;
        logic          r_out;

        // Any cycle where the input agrees with the output restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_out <= 1'b0;
            end else if (w_lvl[i] == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_out <= ~r_out;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign dout[i] = r_out;
    end

endmodule
`default_nettype wire

// File: rtl/lsb_x.sv
`default_nettype none
// ============================================================================
// Module   : lsb_x
// Brief    : LED/switch/button bus peripheral with sticky events and irq.
// Revision : 1.0  initial release
// ============================================================================
module lsb_x
    import lsb_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int NUM_SWI     = 4,
    parameter int NUM_LED     = 8,
    parameter int DBNC_CYCLES = 100000,
    parameter int BTN_POL     = 1,
    parameter int SWI_POL     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stb,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               ack,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [NUM_SWI-1:0] swi_in,
    output logic [NUM_LED-1:0] leds,
    output logic [NUM_BTN-1:0] btn_out,
    output logic [NUM_SWI-1:0] swi_out,
    output logic               irq
);

    localparam logic [31:0] c_evt_mask = evt_mask(NUM_BTN);

    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_SWI-1:0] w_swi;
    logic [NUM_BTN-1:0] r_btn_d;
    logic [NUM_LED-1:0] r_leds;
    logic [31:0]        r_evt;
    logic [31:0]        r_ien;
    logic               r_irq;
    logic [31:0]        w_set;
    logic [31:0]        w_clr;
    logic               w_wr;
    logic [31:0]        w_rdata;

    dbnc_v #(
        .WIDTH  (NUM_BTN),
        .CYCLES (DBNC_CYCLES),
        .POL    (BTN_POL)
    ) u_dbnc_btn (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_in),
        .dout (w_btn)
    );

    dbnc_v #(
        .WIDTH  (NUM_SWI),
        .CYCLES (DBNC_CYCLES),
        .POL    (SWI_POL)
    ) u_dbnc_swi (
        .clk  (clk),
        .rst  (rst),
        .din  (swi_in),
        .dout (w_swi)
    );

    assign w_wr  = stb & we;
    assign w_set = (32'(w_btn & ~r_btn_d) << PRESS_LSB)
                 | (32'(~w_btn & r_btn_d) << RELEASE_LSB);
    assign w_clr = (w_wr && addr == LSB_EVT) ? (data_in & c_evt_mask) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_d <= '0;
            r_leds  <= '0;
            r_evt   <= '0;
            r_ien   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_btn_d <= w_btn;
            // Set is ORed in after the clear so a simultaneous edge is never lost.
            r_evt   <= (r_evt & ~w_clr) | w_set;
            r_irq   <= |(r_evt & r_ien);
            if (w_wr) begin
                case (addr)
                    LSB_DATA: r_leds <= data_in[NUM_LED-1:0];
                    LSB_IEN:  r_ien  <= data_in & c_evt_mask;
                    LSB_LTOG: r_leds <= r_leds ^ data_in[NUM_LED-1:0];
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (stb && !we) begin
            case (addr)
                LSB_DATA: w_rdata = {16'(w_btn), 16'(w_swi)};
                LSB_EVT:  w_rdata = r_evt;
                LSB_IEN:  w_rdata = r_ien;
                default:  w_rdata = 32'(r_leds);
            endcase
        end
    end

    assign data_out = w_rdata;
    assign ack      = stb;
    assign leds     = r_leds;
    assign btn_out  = w_btn;
    assign swi_out  = w_swi;
    assign irq      = r_irq;

endmodule
`default_nettype wire
